// File: rtl/axistream_forwarder.sv
// axistream_forwarder: streams a packet from word memory (address 0 upward) onto AXI-Stream.
// Optional macro FWD_BYTE_LEN_EN: len_to_forwarder is a byte count instead of a word count.
`default_nettype none

module axistream_forwarder #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] TDATA,
    output logic                  TVALID,
    output logic                  TLAST,
    input  logic                  TREADY,
    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    input  logic [DATA_WIDTH-1:0] forwarder_rd_data,
    output logic                  forwarder_rd_en,
    output logic                  forwarder_done,
    input  logic                  ready_for_forwarder,
    input  logic [31:0]           len_to_forwarder
);

    // One extra bit so a full 2^ADDR_WIDTH-word packet is representable.
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] words_q, words_d;
    logic [CW-1:0] reads_q, reads_d;
    logic [CW-1:0] beat_q,  beat_d;
    logic          tvalid_q, tvalid_d;

    logic [32:0]   len_words;
    logic [CW-1:0] words_clip;
    logic          accept;
    logic          last_beat;

`ifdef FWD_BYTE_LEN_EN
    localparam int BYTES = DATA_WIDTH / 8;
    assign len_words = ({1'b0, len_to_forwarder} + 33'(BYTES - 1)) / 33'(BYTES);
`else
    assign len_words = {1'b0, len_to_forwarder};
`endif

    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;
    assign words_clip = (len_words > MAX_WORDS) ? MAX_WORDS[CW-1:0] : len_words[CW-1:0];

    assign last_beat = (beat_q == words_q - CW'(1));
    assign accept    = tvalid_q & TREADY;

    // Data comes straight from memory; memory holds its output while no read is issued.
    assign TDATA             = forwarder_rd_data;
    assign TVALID            = tvalid_q;
    assign TLAST             = tvalid_q & last_beat;
    assign forwarder_rd_addr = reads_q[ADDR_WIDTH-1:0];
    assign forwarder_done    = (state_q == S_FINISH);

    always_comb begin
        state_d         = state_q;
        words_d         = words_q;
        reads_d         = reads_q;
        beat_d          = beat_q;
        tvalid_d        = tvalid_q;
        forwarder_rd_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ready_for_forwarder) begin
                    words_d  = words_clip;
                    reads_d  = '0;
                    beat_d   = '0;
                    tvalid_d = 1'b0;
                    state_d  = (words_clip == '0) ? S_FINISH : S_STREAM;
                end
            end
            S_STREAM: begin
                forwarder_rd_en = (reads_q < words_q) && (!tvalid_q || TREADY);
                if (forwarder_rd_en) begin
                    reads_d = reads_q + CW'(1);
                end
                if (accept) begin
                    beat_d = beat_q + CW'(1);
                end
                if (forwarder_rd_en) begin
                    tvalid_d = 1'b1;
                end else if (accept) begin
                    tvalid_d = 1'b0;
                end
                if (accept && last_beat) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            words_q  <= '0;
            reads_q  <= '0;
            beat_q   <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            words_q  <= words_d;
            reads_q  <= reads_d;
            beat_q   <= beat_d;
            tvalid_q <= tvalid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axistream_forwarder.sv
// Directed testbench for axistream_forwarder with a one-cycle-latency memory model.
`default_nettype none

module tb_axistream_forwarder;

    localparam int AW = 10;
    localparam int DW = 64;
`ifdef FWD_BYTE_LEN_EN
    localparam int UNIT = DW / 8;
`else
    localparam int UNIT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] TDATA;
    logic          TVALID;
    logic          TLAST;
    logic          TREADY = 1'b1;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          rd_en;
    logic          done;
    logic          ready_in = 1'b0;
    logic [31:0]   len_in = '0;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    axistream_forwarder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .TDATA               (TDATA),
        .TVALID              (TVALID),
        .TLAST               (TLAST),
        .TREADY              (TREADY),
        .forwarder_rd_addr   (rd_addr),
        .forwarder_rd_data   (rd_data),
        .forwarder_rd_en     (rd_en),
        .forwarder_done      (done),
        .ready_for_forwarder (ready_in),
        .len_to_forwarder    (len_in)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_val(input int n);
        return 64'hA5A5_0000_0000_0000 | 64'(n);
    endfunction

    // mode 0: TREADY always 1; mode 1: TREADY pattern 1,0,0,1,0,1 repeating.
    task automatic run_packet(input string name, input int len, input int exp_words, input int mode);
        int beats = 0, reads = 0, done_cnt = 0;
        int first_acc = -1, last_acc = -1, done_cyc = -1;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        int budget = exp_words * 3 + 20;
        @(negedge clk);
        ready_in = 1'b1;
        len_in   = 32'(len);
        @(negedge clk);
        ready_in = 1'b0;
        len_in   = 32'hFFFF_FFFF;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (mode == 1) begin
                case (cyc % 6)
                    0, 3, 5: TREADY = 1'b1;
                    default: TREADY = 1'b0;
                endcase
            end else begin
                TREADY = 1'b1;
            end
            ready_in = (mode == 1) && (cyc == 5);
            #1;
            if (prev_stall) begin
                check({name, " stall_valid"}, 64'(TVALID), 64'd1);
                check({name, " stall_data"}, TDATA, prev_data);
                check({name, " stall_last"}, 64'(TLAST), 64'(prev_last));
            end
            if (TVALID && !TREADY) check({name, " rd_en_in_stall"}, 64'(rd_en), 64'd0);
            if (rd_en) begin
                check({name, " rd_addr"}, 64'(rd_addr), 64'(reads % (1 << AW)));
                reads++;
            end
            if (TVALID && TREADY) begin
                check({name, " beat_data"}, TDATA, word_val(beats));
                check({name, " beat_last"}, 64'(TLAST), 64'(beats == exp_words - 1));
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = TVALID && !TREADY;
            prev_data  = TDATA;
            prev_last  = TLAST;
        end
        ready_in = 1'b0;
        TREADY   = 1'b1;
        check({name, " beats"}, 64'(beats), 64'(exp_words));
        check({name, " reads"}, 64'(reads), 64'(exp_words));
        check({name, " done_cnt"}, 64'(done_cnt), 64'd1);
        if (exp_words > 0) begin
            check({name, " done_after_last"}, 64'(done_cyc), 64'(last_acc + 1));
            if (mode == 0) check({name, " throughput"}, 64'(last_acc - first_acc), 64'(exp_words - 1));
        end
    endtask

    initial begin
        int beats;
        int done_cnt;
        for (int i = 0; i < (1 << AW); i++) mem[i] = word_val(i);

        repeat (2) @(negedge clk);
        check("reset TVALID", 64'(TVALID), 64'd0);
        check("reset TLAST", 64'(TLAST), 64'd0);
        check("reset rd_en", 64'(rd_en), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset rd_addr", 64'(rd_addr), 64'd0);
        rst = 1'b0;

        run_packet("len10", 10 * UNIT, 10, 0);
        run_packet("len10_stall", 10 * UNIT, 10, 1);
        run_packet("len1", 1 * UNIT, 1, 0);
        run_packet("len0", 0, 0, 0);
        run_packet("trunc", 2000 * UNIT, 1 << AW, 0);
`ifdef FWD_BYTE_LEN_EN
        run_packet("bytes17", 17, 3, 0);
`endif

        // Abort a 10-word packet with reset after beat 4 has been accepted.
        @(negedge clk);
        ready_in = 1'b1;
        len_in   = 32'(10 * UNIT);
        @(negedge clk);
        ready_in = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 40 && beats < 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (TVALID && TREADY) beats++;
        end
        check("abort beats_before_rst", 64'(beats), 64'd5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort TVALID", 64'(TVALID), 64'd0);
        check("abort TLAST", 64'(TLAST), 64'd0);
        check("abort rd_en", 64'(rd_en), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort rd_addr", 64'(rd_addr), 64'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            #1;
            if (done || TVALID || rd_en) done_cnt++;
        end
        check("abort quiet_after", 64'(done_cnt), 64'd0);
        run_packet("restart", 10 * UNIT, 10, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axistream_forwarder.md
AXISTREAM_FORWARDER -- requirements
Module: axistream_forwarder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: packet memory word-address width.
REQ-002 Parameter DATA_WIDTH, default 64: packet memory word width and TDATA width.
REQ-003 clk  input  1  sole clock; all logic updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 TDATA  output  DATA_WIDTH  AXI-Stream beat data.
REQ-006 TVALID  output  1  AXI-Stream beat valid.
REQ-007 TLAST  output  1  marks the final beat of the packet.
REQ-008 TREADY  input  1  downstream accepts the beat.
REQ-009 forwarder_rd_addr  output  ADDR_WIDTH  packet memory read word address.
REQ-010 forwarder_rd_data  input  DATA_WIDTH  packet memory read data, valid one cycle after rd_en and held while rd_en is low.
REQ-011 forwarder_rd_en  output  1  packet memory read strobe.
REQ-012 forwarder_done  output  1  one-cycle pulse when the packet has been fully forwarded.
REQ-013 ready_for_forwarder  input  1  a packet is available in memory, starting at address 0.
REQ-014 len_to_forwarder  input  32  packet length (unit per REQ-032).

Function
REQ-015 States: IDLE, STREAM, FINISH.
- IDLE: outputs inactive; on ready_for_forwarder=1, latch length, clear read address, go to STREAM.
REQ-016 In STREAM, assert forwarder_rd_en when words remain unread AND (TVALID=0 OR TREADY=1).
- forwarder_rd_addr = index of the word being read.
- The address increments after each read.
REQ-017 TDATA SHALL be driven directly from forwarder_rd_data.
REQ-018 TVALID SHALL rise the cycle after a read and remain high until the beat is accepted (TVALID=1 with TREADY=1).
- Beats with no new read pending SHALL drop TVALID.
REQ-019 TDATA, TVALID and TLAST SHALL stay stable while TVALID=1 and TREADY=0.
REQ-020 Full throughput: with TREADY held at 1, one beat per cycle after the initial 1-cycle read latency.
REQ-021 TLAST SHALL equal TVALID AND (current beat index = word count - 1).
REQ-022 The final beat is accepted when TLAST=1 and TREADY=1.
- Next state: FINISH.
- forwarder_done=1 for exactly that one FINISH cycle.
- Then return to IDLE.
REQ-023 Word count 0: go from IDLE directly to FINISH, with no reads and no beats, then pulse forwarder_done once.
REQ-024 ready_for_forwarder is ignored outside IDLE.
- A new packet may start in the first IDLE cycle after FINISH.
REQ-025 len_to_forwarder is sampled only on the IDLE-to-STREAM transition.
- Later changes have no effect on the current packet.
REQ-026 Word counts above 2^ADDR_WIDTH are truncated to 2^ADDR_WIDTH.

Reset
REQ-027 On rst=1 at a clock edge, the following SHALL take effect next cycle:
- state = IDLE;
- TVALID = TLAST = forwarder_rd_en = forwarder_done = 0;
- forwarder_rd_addr = 0;
- beat counters cleared.
REQ-028 Reset during STREAM aborts the packet; no forwarder_done pulse is produced.
REQ-029 Reset has priority over every other event in the same cycle.

Configuration
REQ-030 Macro FWD_BYTE_LEN_EN selects the length unit.
REQ-031 With FWD_BYTE_LEN_EN defined:
- len_to_forwarder is a byte count;
- word count = ceil(len_to_forwarder / (DATA_WIDTH/8)).
REQ-032 With FWD_BYTE_LEN_EN undefined (default), len_to_forwarder is the word count directly.

Verification
REQ-033 Memory words 0..9 = distinct values, len=10, ready_for_forwarder pulsed, TREADY=1:
- -> 10 consecutive beats in address order;
- TLAST only on beat 9;
- one forwarder_done pulse one cycle after beat 9.
REQ-034 Same packet, TREADY pattern 1,0,0,1,0,1...:
- -> no beat lost or duplicated;
- TDATA/TVALID stable while stalled;
- rd_en never asserted while TVALID=1 and TREADY=0.
REQ-035 len=1:
- -> single beat with TVALID=TLAST=1;
- done pulse next cycle.
REQ-036 len=0:
- -> no beats, no reads;
- exactly one done pulse.
REQ-037 rst asserted after beat 4 of a 10-word packet:
- -> outputs idle next cycle, no done pulse;
- a new start then forwards from address 0.
REQ-038 With FWD_BYTE_LEN_EN defined, len=17, DATA_WIDTH=64:
- -> exactly 3 beats, TLAST on beat 2.
